// File: rtl/ones_count_frame_stats_pkg.sv
// Shared constants and FSM encoding for the ones-count frame statistics block.
package ones_count_frame_stats_pkg;

    localparam int DEF_DATA_WIDTH  = 4;
    localparam int DEF_COUNT_WIDTH = 3;
    localparam int DEF_FRAME_LEN   = 8;
    localparam int DEF_WCNT_WIDTH  = 3;
    localparam int DEF_TOTAL_WIDTH = 6;
    localparam int DEF_THRESH      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ones_count_frame_stats_minmax_track.sv
// Running max/min tracker; min resets to all-ones so the first sample always wins.
module ones_minmax_track #(
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   update,
    input  logic [COUNT_WIDTH-1:0] sample,
    output logic [COUNT_WIDTH-1:0] max_val,
    output logic [COUNT_WIDTH-1:0] min_val
);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            max_val <= '0;
            min_val <= '1;
        end else if (update) begin
            if (sample > max_val) max_val <= sample;
            if (sample < min_val) min_val <= sample;
        end
    end

endmodule

// File: rtl/ones_count_frame_stats.sv
// Collects FRAME_LEN ones-counts per requested frame and holds total/max/min/hit statistics.
module ones_count_frame_stats
    import ones_count_frame_stats_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int FRAME_LEN   = DEF_FRAME_LEN,
    parameter int WCNT_WIDTH  = DEF_WCNT_WIDTH,
    parameter int TOTAL_WIDTH = DEF_TOTAL_WIDTH,
    parameter int THRESH      = DEF_THRESH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   count_valid,
    input  logic [COUNT_WIDTH-1:0] bit_count,
    output logic [TOTAL_WIDTH-1:0] total,
    output logic [COUNT_WIDTH-1:0] max_count,
    output logic [COUNT_WIDTH-1:0] min_count,
    output logic [WCNT_WIDTH:0]    hit_cnt,
    output logic [WCNT_WIDTH:0]    word_cnt,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   range_err,
    output state_t                 state_dbg
);

    localparam int WW = WCNT_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] MAX_LEGAL = COUNT_WIDTH'(DATA_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] THRESH_C  = COUNT_WIDTH'(THRESH);
    localparam logic [WW-1:0]          LAST_IDX  = WW'(FRAME_LEN - 1);

    state_t state, state_next;
    logic   clear, present, accept, drop, last_accept;
    logic [COUNT_WIDTH-1:0] min_int;

    // A sample coinciding with abort is neither accepted nor flagged.
    assign clear       = (state == ST_IDLE) && start;
    assign present     = (state == ST_ACCUM) && count_valid && !abort;
    assign accept      = present && (bit_count <= MAX_LEGAL);
    assign drop        = present && (bit_count > MAX_LEGAL);
    assign last_accept = accept && (word_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_ACCUM;
            ST_ACCUM: begin
                if (abort)            state_next = ST_IDLE;
                else if (last_accept) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == ST_ACCUM);
        frame_done = (state == ST_DONE);
        state_dbg  = state;
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            total     <= '0;
            hit_cnt   <= '0;
            word_cnt  <= '0;
            range_err <= 1'b0;
        end else begin
            if (accept) begin
                total    <= total + TOTAL_WIDTH'(bit_count);
                word_cnt <= word_cnt + WW'(1);
                if (bit_count >= THRESH_C) hit_cnt <= hit_cnt + WW'(1);
            end
            if (drop) range_err <= 1'b1;
        end
    end

    ones_minmax_track #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_minmax (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .update  (accept),
        .sample  (bit_count),
        .max_val (max_count),
        .min_val (min_int)
    );

    // The all-ones seed is internal only; an empty frame reports 0.
    assign min_count = (word_cnt == '0) ? '0 : min_int;

endmodule
